sram_mem_ctrl: RTL

Multi-cycle controller that sequences data-memory accesses issued by the execute/memory stages onto a 16-bit-wide asynchronous external SRAM. It latches the ALU-computed address and the store data, splits each 32-bit word into two half-word SRAM phases with a programmable wait count, and freezes the pipeline until the access completes. It sits between the EXE/MEM pipeline register and the SRAM pins.

---
 rtl/sram_mem_ctrl_if.sv | 29 ++
 rtl/sram_mem_ctrl.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/sram_mem_ctrl_if.sv
// sram_mem_ctrl_if: bundles the pipeline request/response signals and the
// external 16-bit SRAM pins used by sram_mem_ctrl.
// slave  = controller side, master = pipeline/pad side.
`timescale 1ns/1ps
interface sram_mem_ctrl_if #(
    parameter int SRAM_AW = 18
);
    logic               mem_read;
    logic               mem_write;
    logic [31:0]        addr;
    logic [31:0]        wdata;
    logic [31:0]        rdata;
    logic               ready;
    logic [SRAM_AW-1:0] sram_addr;
    logic [15:0]        sram_dq_out;
    logic [15:0]        sram_dq_in;
    logic               sram_dq_oe;
    logic               sram_we_n;

    modport slave (
        input  mem_read, mem_write, addr, wdata, sram_dq_in,
        output rdata, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
    );

    modport master (
        output mem_read, mem_write, addr, wdata, sram_dq_in,
        input  rdata, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
    );
endinterface

// File: rtl/sram_mem_ctrl.sv
// sram_mem_ctrl: sequences one 32-bit data-memory access as two half-word
// phases on a 16-bit asynchronous SRAM, holding each phase WAIT_CYCLES
// cycles and holding ready low (pipeline freeze) until the word is done.
// Optional feature macro SRAM_ADDR_OFFSET_EN: when defined, data memory is
// mapped at byte address 1024, i.e. the SRAM sees (addr - 1024).
//
// state  | meaning
// IDLE   | waiting for mem_read/mem_write, latches the request
// LOW    | low half-word on the bus (sram_addr LSB = 0)
// HIGH   | high half-word on the bus (sram_addr LSB = 1)
// DONE   | access complete, ready = 1, rdata valid after a read
`timescale 1ns/1ps
module sram_mem_ctrl #(
    parameter int WAIT_CYCLES = 5,
    parameter int SRAM_AW     = 18
) (
    input  logic            clk,
    input  logic            rst,
    sram_mem_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOW  = 2'd1,
        S_HIGH = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [3:0] CNT_LAST = 4'(WAIT_CYCLES - 1);

    state_t             state;
    state_t             state_nxt;
    logic [3:0]         cnt;
    logic [3:0]         cnt_nxt;
    logic               req;
    logic               phase_end;
    logic               busy;
    logic [31:0]        addr_eff;
    logic [SRAM_AW-2:0] word_addr;

    logic               is_write_q;
    logic [15:0]        wdata_hi_q;
    logic [SRAM_AW-1:0] sram_addr_q;
    logic [15:0]        sram_dq_out_q;
    logic [31:0]        rdata_q;

    assign req       = bus.mem_read | bus.mem_write;
    assign phase_end = (cnt == CNT_LAST);
    assign busy      = (state == S_LOW) || (state == S_HIGH);

`ifdef SRAM_ADDR_OFFSET_EN
    assign addr_eff = bus.addr - 32'd1024;
`else
    assign addr_eff = bus.addr;
`endif

    // Byte offset bits are dropped and the word index is truncated to fit.
    assign word_addr = (SRAM_AW-1)'(addr_eff >> 2);

    // State register and phase wait counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state logic and phase counting.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            S_IDLE: begin
                if (req) begin
                    state_nxt = S_LOW;
                    cnt_nxt   = 4'd0;
                end
            end
            S_LOW: begin
                if (phase_end) begin
                    state_nxt = S_HIGH;
                    cnt_nxt   = 4'd0;
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
            S_HIGH: begin
                if (phase_end) begin
                    state_nxt = S_DONE;
                    cnt_nxt   = 4'd0;
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = 4'd0;
            end
        endcase
    end

    // Handshake and pad control decoded from state; a request waiting in
    // IDLE already freezes the pipeline.
    always_comb begin
        bus.ready      = 1'b0;
        bus.sram_dq_oe = 1'b0;
        bus.sram_we_n  = 1'b1;
        if (state == S_DONE || (state == S_IDLE && !req)) begin
            bus.ready = 1'b1;
        end
        if (busy && is_write_q) begin
            bus.sram_dq_oe = 1'b1;
            bus.sram_we_n  = 1'b0;
        end
    end

    // Request latch, SRAM address/data registers and read-data capture.
    // Inputs are only sampled in IDLE, so changes while busy are ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            is_write_q    <= 1'b0;
            wdata_hi_q    <= 16'd0;
            sram_addr_q   <= '0;
            sram_dq_out_q <= 16'd0;
            rdata_q       <= 32'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req) begin
                        is_write_q    <= bus.mem_write;
                        wdata_hi_q    <= bus.wdata[31:16];
                        sram_addr_q   <= {word_addr, 1'b0};
                        sram_dq_out_q <= bus.wdata[15:0];
                    end
                end
                S_LOW: begin
                    if (phase_end) begin
                        sram_addr_q[0] <= 1'b1;
                        sram_dq_out_q  <= wdata_hi_q;
                        if (!is_write_q) begin
                            rdata_q[15:0] <= bus.sram_dq_in;
                        end
                    end
                end
                S_HIGH: begin
                    if (phase_end && !is_write_q) begin
                        rdata_q[31:16] <= bus.sram_dq_in;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.sram_addr   = sram_addr_q;
    assign bus.sram_dq_out = sram_dq_out_q;
    assign bus.rdata       = rdata_q;

endmodule
